// File: rtl/line_tap_buffer_pkg.sv
// Shared constants and helpers for the line tap buffer: default video geometry
// and the counter-width function used by every file of the block.
package line_tap_buffer_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_IMG_HDISP = 640;
    localparam int DEF_IMG_VDISP = 480;
    localparam int DEF_N_TAPS    = 2;

    // Ceiling log2, never below 1 so a degenerate geometry still gets a real counter bit.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/line_tap_buffer_if.sv
// Pixel stream interface of the line tap buffer: input stream plus the
// presented pixel, its vertical taps and its frame position.
interface line_tap_buffer_if
    import line_tap_buffer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_TAPS    = DEF_N_TAPS,
    parameter int IMG_HDISP = DEF_IMG_HDISP,
    parameter int IMG_VDISP = DEF_IMG_VDISP
) ();

    localparam int COL_W = clog2(IMG_HDISP);
    localparam int ROW_W = clog2(IMG_VDISP);

    logic                     sof;
    logic                     ce;
    logic [DATA_W-1:0]        shift_in;
    logic                     out_valid;
    logic [DATA_W-1:0]        pix_cur;
    logic [N_TAPS*DATA_W-1:0] taps;
    logic [COL_W-1:0]         out_col;
    logic [ROW_W-1:0]         out_row;
    logic                     line_end;

    modport master (
        output sof, ce, shift_in,
        input  out_valid, pix_cur, taps, out_col, out_row, line_end
    );

    modport slave (
        input  sof, ce, shift_in,
        output out_valid, pix_cur, taps, out_col, out_row, line_end
    );

endinterface

// File: rtl/line_tap_buffer_line_ram.sv
// One line of pixel storage: single-port, read-before-write, registered read.
// The pre-write word is also exposed so the next stage can store it on the same edge.
module line_tap_buffer_line_ram
    import line_tap_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_IMG_HDISP
) (
    input  logic                       clk,
    input  logic                       ce,
    input  logic [clog2(DEPTH)-1:0]    addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          old_word,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // old_word is the content before this edge's write; it feeds the next line stage.
    assign old_word = mem[addr];

    // NOTE: the storage array has no reset; the top-row mask alone decides what reaches the outputs.
    always_ff @(posedge clk) begin
        if (ce) begin
            rd_data   <= mem[addr];
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/line_tap_buffer.sv
// Multi-line tap buffer: tracks frame position, chains N_TAPS line RAMs by column
// and presents the current pixel with the co-located pixels of previous lines.
module line_tap_buffer
    import line_tap_buffer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IMG_HDISP = DEF_IMG_HDISP,
    parameter int IMG_VDISP = DEF_IMG_VDISP,
    parameter int N_TAPS    = DEF_N_TAPS
) (
    input  logic           clk,
    input  logic           rst,
    line_tap_buffer_if.slave bus
);

    localparam int COL_W = clog2(IMG_HDISP);
    localparam int ROW_W = clog2(IMG_VDISP);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_HDISP - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_VDISP - 1);

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Position of the pixel accepted this cycle; sof forces it to the frame origin.
    logic [COL_W-1:0] acc_col;
    logic [ROW_W-1:0] acc_row;
    logic             acc_last_col;
    logic             acc_last_row;

    logic [N_TAPS-1:0]        pad_q;
    logic [DATA_W-1:0]        chain_in [N_TAPS];
    logic [DATA_W-1:0]        old_word [N_TAPS];
    logic [DATA_W-1:0]        rd_data  [N_TAPS];
    logic [N_TAPS*DATA_W-1:0] taps_w;

    always_comb begin
        acc_col      = bus.sof ? '0 : col;
        acc_row      = bus.sof ? '0 : row;
        acc_last_col = (acc_col == LAST_COL);
        acc_last_row = (acc_row == LAST_ROW);
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.ce) begin
            if (acc_last_col) begin
                col <= '0;
                row <= acc_last_row ? '0 : acc_row + 1'b1;
            end else begin
                col <= acc_col + 1'b1;
                row <= acc_row;
            end
        end else if (bus.sof) begin
            col <= '0;
            row <= '0;
        end
    end

    // Stage 0 stores the incoming pixel; stage k stores what stage k-1 held at this column.
    for (genvar k = 0; k < N_TAPS; k++) begin : g_line
        if (k == 0) begin : g_head
            assign chain_in[k] = bus.shift_in;
        end else begin : g_link
            assign chain_in[k] = old_word[k-1];
        end

        line_tap_buffer_line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_HDISP)
        ) u_line_ram (
            .clk      (clk),
            .ce       (bus.ce),
            .addr     (acc_col),
            .wr_data  (chain_in[k]),
            .old_word (old_word[k]),
            .rd_data  (rd_data[k])
        );
    end

    // Tap k+1 lies above the frame top while the accepted row is <= k; reset masks every tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= '1;
        end else if (bus.ce) begin
            for (int k = 0; k < N_TAPS; k++) begin
                pad_q[k] <= (int'(acc_row) <= k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.pix_cur   <= '0;
            bus.out_col   <= '0;
            bus.out_row   <= '0;
            bus.line_end  <= 1'b0;
        end else begin
            bus.out_valid <= bus.ce;
            if (bus.ce) begin
                bus.pix_cur  <= bus.shift_in;
                bus.out_col  <= acc_col;
                bus.out_row  <= acc_row;
                bus.line_end <= acc_last_col;
            end
        end
    end

    always_comb begin
        taps_w = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (!pad_q[k]) begin
                taps_w[k*DATA_W +: DATA_W] = rd_data[k];
            end
        end
    end

    assign bus.taps = taps_w;

endmodule
